// File: rtl/poisson_rate_decoder.sv
// Purpose: decodes a Poisson spike train into a rate estimate by counting spikes over 2^WINDOW_LOG2 valid samples.
// Latency: rate_out/rate_valid update one cycle after the last sample of a window; windows run back-to-back.
// Backpressure: result held on valid/ready; a new result overwrites an unconsumed one and sets sticky overrun.
module poisson_rate_decoder #(
    parameter int DATA_WIDTH  = 8,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  spike_in,
    input  logic                  spike_valid,
    output logic [DATA_WIDTH-1:0] rate_out,
    output logic                  rate_valid,
    input  logic                  rate_ready,
    output logic                  busy,
    output logic                  overrun
);

    // Scaled count is always DATA_WIDTH+1 bits: the extra bit flags a full-window count needing saturation.
    localparam int SW = DATA_WIDTH + 1;
    localparam int CW = WINDOW_LOG2 + 1;
    localparam logic [WINDOW_LOG2-1:0] ONE_S = 1;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [WINDOW_LOG2-1:0]  r_sample_cnt;
    logic [CW-1:0]           r_spike_cnt;
    logic [DATA_WIDTH-1:0]   r_rate;
    logic                    r_rate_vld;
    logic                    r_overrun;
    logic                    w_accept;
    logic                    w_last;
    logic [CW-1:0]           w_total;
    logic [SW-1:0]           w_scaled;
    logic [DATA_WIDTH-1:0]   w_rate_sat;

    assign w_accept = (r_state == ACCUM) && enable && spike_valid;
    assign w_last   = w_accept && (r_sample_cnt == '1);
    assign w_total  = r_spike_cnt + CW'(spike_in);

    // Normalise the window count to the output range: shift up when the window is shorter than the rate scale, down otherwise.
    generate
        if (DATA_WIDTH >= WINDOW_LOG2) begin : g_scale_up
            localparam int unsigned UP_SH = DATA_WIDTH - WINDOW_LOG2;
            assign w_scaled = SW'(w_total) << UP_SH;
        end else begin : g_scale_dn
            localparam int unsigned DN_SH = WINDOW_LOG2 - DATA_WIDTH;
            assign w_scaled = SW'(w_total >> DN_SH);
        end
    endgenerate

    assign w_rate_sat = w_scaled[DATA_WIDTH] ? '1 : w_scaled[DATA_WIDTH-1:0];

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and busy decode; clear outranks enable, and enable low always drops back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state == ACCUM);
        if (clear) begin
            w_state_nxt = enable ? ACCUM : IDLE;
        end else if (!enable) begin
            w_state_nxt = IDLE;
        end else if (r_state == IDLE) begin
            w_state_nxt = ACCUM;
        end
    end

    // Window counters: discarded on clear or abort, restarted at each window boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
            r_spike_cnt  <= '0;
        end else if (clear || !enable) begin
            r_sample_cnt <= '0;
            r_spike_cnt  <= '0;
        end else if (w_last) begin
            r_sample_cnt <= '0;
            r_spike_cnt  <= '0;
        end else if (w_accept) begin
            r_sample_cnt <= r_sample_cnt + ONE_S;
            r_spike_cnt  <= w_total;
        end
    end

    // Result register with valid/ready handshake; a load while still unconsumed flags overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rate     <= '0;
            r_rate_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (clear) begin
            r_rate_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_last) begin
            r_rate     <= w_rate_sat;
            r_rate_vld <= 1'b1;
            if (r_rate_vld && !rate_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_rate_vld && rate_ready) begin
            r_rate_vld <= 1'b0;
        end
    end

    assign rate_out   = r_rate;
    assign rate_valid = r_rate_vld;
    assign overrun    = r_overrun;

endmodule
